// File: rtl/seq_add_chunked_pkg.sv
// Shared definitions for the chunked sequential adder.
//   CHUNK_W          : width of the reused adder slice
//   seq_add_state_t  : control FSM state encoding
//   cnt_width()      : chunk counter width, never below one bit
package seq_add_chunked_pkg;

    localparam int unsigned CHUNK_W = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } seq_add_state_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_add_chunked_cond_sum32.sv
// cond_sum32: 32-bit conditional-sum adder slice.
// The upper half is computed for both possible carries and selected by the lower-half carry.
//   a_i, b_i  [31:0] : operands
//   cin_i            : carry-in
//   s_o       [31:0] : sum
//   cout_o           : carry-out of bit 31
module cond_sum32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    output logic [31:0] s_o,
    output logic        cout_o
);

    logic [16:0] lo;
    logic [16:0] hi0;
    logic [16:0] hi1;

    always_comb begin
        lo  = {1'b0, a_i[15:0]} + {1'b0, b_i[15:0]} + {16'b0, cin_i};
        hi0 = {1'b0, a_i[31:16]} + {1'b0, b_i[31:16]};
        hi1 = {1'b0, a_i[31:16]} + {1'b0, b_i[31:16]} + 17'd1;
        s_o[15:0] = lo[15:0];
        if (lo[16]) begin
            s_o[31:16] = hi1[15:0];
            cout_o     = hi1[16];
        end else begin
            s_o[31:16] = hi0[15:0];
            cout_o     = hi0[16];
        end
    end

endmodule

// File: rtl/seq_add_chunked.sv
// seq_add_chunked: multi-cycle wide adder/subtractor reusing one 32-bit slice, LSB chunk first,
// with the inter-chunk carry registered. Valid/ready handshake on both sides.
// Optional feature macro: SEQ_ADD_FLAGS_EN adds registered zero_o / ovf_o result flags.
//   clk, rst (async, active-high)
//   in_valid_i / in_ready_o     : operand handshake (in_ready_o is combinational from out_ready_i)
//   a_i, b_i [DATA_W-1:0]       : operands
//   cin_i                       : carry-in, ignored when sub_i=1
//   sub_i                       : 1 = a - b, 0 = a + b + cin
//   out_valid_o / out_ready_i   : result handshake
//   sum_o [DATA_W-1:0], cout_o  : result and carry-out (for sub: 1 = no borrow)
//   zero_o, ovf_o               : [SEQ_ADD_FLAGS_EN] sum == 0, signed overflow
module seq_add_chunked
    import seq_add_chunked_pkg::*;
#(
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              cin_i,
    input  logic              sub_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] sum_o,
    output logic              cout_o
`ifdef SEQ_ADD_FLAGS_EN
    ,
    output logic              zero_o,
    output logic              ovf_o
`endif
);

    localparam int unsigned NCHUNK = DATA_W / CHUNK_W;
    localparam int unsigned CNT_W  = cnt_width(NCHUNK);
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(NCHUNK - 1);

    if (((DATA_W % CHUNK_W) != 0) || (DATA_W < 64)) begin : g_bad_width
        $error("seq_add_chunked: DATA_W must be a multiple of 32 and >= 64");
    end

    seq_add_state_t state_q, state_d;

    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;        // already inverted for subtraction
    logic              c_q, c_d;        // carry into the current chunk
    logic [CNT_W-1:0]  chunk_cnt_q, chunk_cnt_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              cout_q, cout_d;
`ifdef SEQ_ADD_FLAGS_EN
    logic              zero_q, zero_d;
    logic              ovf_q, ovf_d;
`endif

    logic [CHUNK_W-1:0] a_chunk, b_chunk, s_chunk;
    logic               cout_chunk;
    logic               accept;
    logic               last_chunk;

    assign accept     = in_valid_i && in_ready_o;
    assign last_chunk = (chunk_cnt_q == LastCnt);

    // Chunk select
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int k = 0; k < int'(NCHUNK); k++) begin
            if (chunk_cnt_q == CNT_W'(k)) begin
                a_chunk = a_q[k*CHUNK_W +: CHUNK_W];
                b_chunk = b_q[k*CHUNK_W +: CHUNK_W];
            end
        end
    end

    cond_sum32 u_cond_sum32 (
        .a_i    (a_chunk),
        .b_i    (b_chunk),
        .cin_i  (c_q),
        .s_o    (s_chunk),
        .cout_o (cout_chunk)
    );

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StBusy;
            StBusy: if (last_chunk) state_d = StDone;
            StDone: begin
                // Retire; a simultaneous accept goes straight back to BUSY
                if (out_ready_i) state_d = in_valid_i ? StBusy : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        unique case (state_q)
            StIdle:  in_ready_o = ~rst;
            StBusy:  in_ready_o = 1'b0;
            StDone: begin
                out_valid_o = 1'b1;
                in_ready_o  = out_ready_i && !rst;
            end
            default: ;
        endcase
    end

    // Datapath next state
    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        chunk_cnt_d = chunk_cnt_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
`ifdef SEQ_ADD_FLAGS_EN
        zero_d      = zero_q;
        ovf_d       = ovf_q;
`endif
        if (accept) begin
            a_d         = a_i;
            b_d         = sub_i ? ~b_i : b_i;
            c_d         = sub_i | cin_i;
            chunk_cnt_d = '0;
            sum_d       = '0;
            cout_d      = 1'b0;
`ifdef SEQ_ADD_FLAGS_EN
            zero_d      = 1'b0;
            ovf_d       = 1'b0;
`endif
        end else if (state_q == StBusy) begin
            for (int k = 0; k < int'(NCHUNK); k++) begin
                if (chunk_cnt_q == CNT_W'(k)) begin
                    sum_d[k*CHUNK_W +: CHUNK_W] = s_chunk;
                end
            end
            c_d = cout_chunk;
            if (last_chunk) begin
                cout_d = cout_chunk;
`ifdef SEQ_ADD_FLAGS_EN
                zero_d = (sum_d == '0);
                ovf_d  = (a_q[DATA_W-1] == b_q[DATA_W-1]) &&
                         (s_chunk[CHUNK_W-1] != a_q[DATA_W-1]);
`endif
            end else begin
                chunk_cnt_d = chunk_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= 1'b0;
            chunk_cnt_q <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
`ifdef SEQ_ADD_FLAGS_EN
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            chunk_cnt_q <= chunk_cnt_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
`ifdef SEQ_ADD_FLAGS_EN
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign sum_o  = sum_q;
    assign cout_o = cout_q;
`ifdef SEQ_ADD_FLAGS_EN
    assign zero_o = zero_q;
    assign ovf_o  = ovf_q;
`endif

endmodule
